// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the instruction sequencer: state encoding
// and the instruction-register layout {op_ext1, op_ext0, opcode[4:0]}.
package ctrl_seq_pkg;
  localparam int IR_W        = 7;
  localparam int IR_OPC_LSB  = 0;
  localparam int IR_OPC_MSB  = 4;
  localparam int IR_EXT0_BIT = 5;
  localparam int IR_EXT1_BIT = 6;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED, S_ERROR
  } ctrl_seq_state_t;
endpackage

// File: rtl/ctrl_seq_if.sv
// Sequencer-facing bundle: memory handshakes, decoder inputs, branch info and
// status. master = sequencer side, slave = memories/decoder/datapath side.
interface ctrl_seq_if #(parameter int PC_W = 16);
  logic                         start;
  logic                         imem_req;
  logic [PC_W-1:0]              imem_addr;
  logic                         imem_ack;
  logic [ctrl_seq_pkg::IR_W-1:0] imem_rdata;
  logic [ctrl_seq_pkg::IR_W-1:0] ir;
  logic                         dec_halt;
  logic                         dec_reg_write;
  logic                         dec_mem_write;
  logic                         dec_sel_wb;
  logic                         dec_jump;
  logic                         br_taken;
  logic [PC_W-1:0]              br_target;
  logic                         dmem_req;
  logic                         dmem_we;
  logic                         dmem_ack;
  logic                         rf_we;
  logic                         busy;
  logic                         halted;
  logic                         err;

  modport master (
    input  start, imem_ack, imem_rdata, dec_halt, dec_reg_write, dec_mem_write,
           dec_sel_wb, dec_jump, br_taken, br_target, dmem_ack,
    output imem_req, imem_addr, ir, dmem_req, dmem_we, rf_we, busy, halted, err
  );
  modport slave (
    output start, imem_ack, imem_rdata, dec_halt, dec_reg_write, dec_mem_write,
           dec_sel_wb, dec_jump, br_taken, br_target, dmem_ack,
    input  imem_req, imem_addr, ir, dmem_req, dmem_we, rf_we, busy, halted, err
  );
endinterface

// File: rtl/ctrl_seq_wdog.sv
// Handshake watchdog: counts consecutive no-ack cycles of one FETCH/MEM visit
// and flags expiry on the 2^TO_W-1'th waiting cycle.
module ctrl_seq_wdog #(
  parameter int TO_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  // cnt holds the waits already taken, so the current cycle is wait cnt+1
  localparam logic [TO_W-1:0] LAST = {{(TO_W-1){1'b1}}, 1'b0};

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + TO_W'(1);
  end

  assign expire = inc && (cnt == LAST);
endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/[MEM]/WB sequencer around the control decoder.
// Define CTRL_SEQ_TIMEOUT_EN to abort stalled handshakes into ERROR.
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int PC_W = 16,
  parameter int TO_W = 4
) (
  input logic        clk,
  input logic        rst_n,
  ctrl_seq_if.master bus
);
  ctrl_seq_state_t state, nxt;
  logic [PC_W-1:0] pc;
  logic [IR_W-1:0] ir_q;
  logic            imem_req_q, dmem_req_q, wb_q, busy_q, halted_q, err_q;
  logic            to_expire;

`ifdef CTRL_SEQ_TIMEOUT_EN
  logic wait_st;
  logic to_clr;
  assign wait_st = (state == S_FETCH && !bus.imem_ack) || (state == S_MEM && !bus.dmem_ack);
  assign to_clr  = !(state inside {S_FETCH, S_MEM});

  ctrl_seq_wdog #(.TO_W(TO_W)) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (to_clr),
    .inc    (wait_st),
    .expire (to_expire)
  );
`else
  assign to_expire = 1'b0;
`endif

  // an ack always beats a simultaneous watchdog expiry
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE, S_HALTED, S_ERROR: if (bus.start) nxt = S_FETCH;
      S_FETCH:  if (bus.imem_ack) nxt = S_DECODE;
                else if (to_expire) nxt = S_ERROR;
      S_DECODE: nxt = bus.dec_halt ? S_HALTED : S_EXEC;
      S_EXEC:   nxt = (bus.dec_mem_write || bus.dec_sel_wb) ? S_MEM : S_WB;
      S_MEM:    if (bus.dmem_ack) nxt = S_WB;
                else if (to_expire) nxt = S_ERROR;
      S_WB:     nxt = S_FETCH;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir_q       <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      wb_q       <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= nxt;
      // status flags are registered copies of the next-state decode
      imem_req_q <= (nxt == S_FETCH);
      dmem_req_q <= (nxt == S_MEM);
      wb_q       <= (nxt == S_WB);
      busy_q     <= (nxt inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB});
      halted_q   <= (nxt == S_HALTED);
      err_q      <= (nxt == S_ERROR);
      case (state)
        S_IDLE, S_HALTED, S_ERROR: if (bus.start) pc <= '0;
        S_FETCH: if (bus.imem_ack) ir_q <= bus.imem_rdata;
        S_WB:    pc <= (bus.br_taken || bus.dec_jump) ? bus.br_target : pc + PC_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc;
  assign bus.ir        = ir_q;
  assign bus.dmem_req  = dmem_req_q;
  assign bus.dmem_we   = dmem_req_q && bus.dec_mem_write;
  assign bus.rf_we     = wb_q && bus.dec_reg_write;
  assign bus.busy      = busy_q;
  assign bus.halted    = halted_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomized bench for ctrl_sequencer: per-instruction transaction model
// predicts fetch address, cycle count, strobe counts and next PC.
module tb_ctrl_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          both_hi = 0;
  logic [15:0] mpc;
  logic [6:0]  ins;
  int          n;

  ctrl_seq_if #(.PC_W(16)) bus ();

  ctrl_sequencer #(.PC_W(16), .TO_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // bench decoder: bit5 = store, bit6&~bit5 = load, 1F = halt, 1E = jump
  function automatic logic f_mw(input logic [6:0] i);   return i[5];               endfunction
  function automatic logic f_sw(input logic [6:0] i);   return i[6] & ~i[5];       endfunction
  function automatic logic f_rw(input logic [6:0] i);   return ~i[5];              endfunction
  function automatic logic f_jmp(input logic [6:0] i);  return i[4:0] == 5'h1E;    endfunction
  function automatic logic f_halt(input logic [6:0] i); return i[4:0] == 5'h1F;    endfunction

  assign bus.dec_mem_write = f_mw(bus.ir);
  assign bus.dec_sel_wb    = f_sw(bus.ir);
  assign bus.dec_reg_write = f_rw(bus.ir);
  assign bus.dec_jump      = f_jmp(bus.ir);
  assign bus.dec_halt      = f_halt(bus.ir);

  always @(negedge clk) if (bus.imem_req && bus.dmem_req) both_hi++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] outs();
    return {2'b0, bus.ir, bus.imem_addr, bus.imem_req, bus.dmem_req, bus.dmem_we,
            bus.rf_we, bus.busy, bus.halted, bus.err};
  endfunction

  task automatic do_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    mpc = 16'h0000;
  endtask

  // entered at a negedge with the DUT in FETCH; leaves at the next FETCH/HALTED/ERROR
  task automatic run_instr(input string tag, input logic [6:0] i, input int wi, input int wd,
                           input logic tk, input logic [15:0] tgt);
    int cyc = 0, iw = 0, dw = 0, rfc = 0, dmc = 0, wec = 0, irbad = 0, exp_cyc;
    logic [15:0] a0 = 16'h0;
    bit got_a = 0, facked = 0;
    bit hlt = f_halt(i);
    bit mem = f_mw(i) | f_sw(i);
    bus.br_taken  = tk;
    bus.br_target = tgt;
    while (!(facked && (bus.imem_req || bus.halted || bus.err)) && cyc < 200) begin
      cyc++;
      if (facked && bus.ir !== i) irbad++;
      if (bus.imem_req) begin
        if (!got_a) begin a0 = bus.imem_addr; got_a = 1; end
        if (iw == wi) begin bus.imem_ack = 1'b1; bus.imem_rdata = i; facked = 1; end
        else begin bus.imem_ack = 1'b0; bus.imem_rdata = 7'($urandom); iw++; end
      end else bus.imem_ack = ($urandom % 4 == 0);
      if (bus.dmem_req) begin
        dmc++;
        if (bus.dmem_we) wec++;
        if (dw == wd) bus.dmem_ack = 1'b1;
        else begin bus.dmem_ack = 1'b0; dw++; end
      end else bus.dmem_ack = ($urandom % 4 == 0);
      if (bus.rf_we) rfc++;
      bus.start = ($urandom % 8 == 0);
      @(negedge clk);
    end
    bus.start = 1'b0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    exp_cyc = 2 + wi + (hlt ? 0 : 2 + (mem ? 1 + wd : 0));
    chk({tag, ".addr"}, a0, mpc);
    chk({tag, ".cycles"}, cyc, exp_cyc);
    chk({tag, ".rf_we"}, rfc, (!hlt && f_rw(i)) ? 1 : 0);
    chk({tag, ".dmem_req"}, dmc, (!hlt && mem) ? 1 + wd : 0);
    chk({tag, ".dmem_we"}, wec, (!hlt && f_mw(i)) ? 1 + wd : 0);
    chk({tag, ".ir_stable"}, irbad, 0);
    if (hlt) begin
      chk({tag, ".halted"}, bus.halted, 1);
      chk({tag, ".pc_hold"}, bus.imem_addr, mpc);
    end else if (tk || f_jmp(i)) mpc = tgt;
    else mpc = mpc + 16'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bus.start = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.dmem_ack = 1'b0;
    bus.br_taken = 1'b0; bus.br_target = '0; mpc = '0;
    #1 chk("reset_outs", outs(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk) chk("idle_after_rst", outs(), 0);

    do_start();
    chk("first_fetch_req", bus.imem_req, 1);
    run_instr("alu",    7'h05, 0, 0, 1'b0, 16'h1234);
    run_instr("store",  7'h23, 0, 3, 1'b0, 16'h0000);
    run_instr("jmp10",  7'h1E, 1, 0, 1'b0, 16'h0010);
    run_instr("br",     7'h05, 0, 0, 1'b1, 16'h0002);
    run_instr("at2",    7'h05, 0, 0, 1'b0, 16'h0000);
    run_instr("toffff", 7'h05, 0, 0, 1'b1, 16'hFFFF);
    run_instr("wrap",   7'h43, 0, 1, 1'b0, 16'h0000);
    run_instr("at0",    7'h05, 0, 0, 1'b0, 16'h0000);
    run_instr("halt",   7'h1F, 2, 0, 1'b0, 16'h0000);
    repeat (3) @(negedge clk);
    chk("halt_stays", {bus.halted, bus.busy}, 2'b10);
    do_start();
    run_instr("restart", 7'h05, 0, 0, 1'b0, 16'h0000);

    for (int k = 0; k < 60; k++) begin
      ins = 7'($urandom);
      run_instr("rnd", ins, $urandom % 4, $urandom % 4, 1'($urandom), 16'($urandom));
      if (f_halt(ins)) do_start();
    end

    // reset while a load's data request is pending
    bus.imem_ack = 1'b1; bus.imem_rdata = 7'h43;
    @(negedge clk) bus.imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("mem_pending", bus.dmem_req, 1);
    rst_n = 1'b0;
    #1 chk("rst_mid_mem", outs(), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_mid_rst", outs(), 0);
    do_start();
    run_instr("post_rst", 7'h05, 0, 0, 1'b0, 16'h0000);

`ifdef CTRL_SEQ_TIMEOUT_EN
    n = 0;
    while (bus.imem_req && n < 40) begin n++; @(negedge clk); end
    chk("to_fetch_cycles", n, 15);
    chk("to_err", {bus.err, bus.imem_req, bus.busy}, 3'b100);
    do_start();
    chk("to_err_clear", bus.err, 0);
    run_instr("ack15", 7'h05, 14, 0, 1'b0, 16'h0000);
    chk("ack15_no_err", bus.err, 0);
`endif

    chk("req_exclusive", both_hi, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Multi-cycle instruction sequencer wrapped around the combinational control decoder. Owns the program counter and instruction register, drives the instruction- and data-memory request/acknowledge handshakes, and gates the decoder's register-write, memory and branch/jump outputs into single-cycle strobes. It sits between the memories, the decoder and the datapath, and turns one decoded opcode into a fixed sequence of FETCH, DECODE, EXEC, optional MEM, and WB cycles.

## Interface
- `PC_W`, 16, program counter width.
- `TO_W`, 4, handshake timeout counter width. Used only with the timeout feature.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse. Starts execution at PC 0 from IDLE, HALTED or ERROR.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  PC_W  fetch address, equal to the current PC.
- `imem_ack`  in  1  fetch data valid this cycle.
- `imem_rdata`  in  7  instruction word: {op_ext1, op_ext0, opcode4..opcode0}.
- `ir`  out  7  instruction register, drives the decoder inputs.
- `dec_halt`, `dec_reg_write`, `dec_mem_write`, `dec_sel_wb`, `dec_jump`  in  1 each  decoder outputs.
- `br_taken`  in  1  resolved branch condition from the datapath.
- `br_target`  in  PC_W  branch/jump target.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  write qualifier, valid while `dmem_req` is high.
- `dmem_ack`  in  1  data access complete.
- `rf_we`  out  1  register-file write strobe.
- `busy`  out  1  high in FETCH, DECODE, EXEC, MEM and WB.
- `halted`  out  1  high in HALTED.
- `err`  out  1  high in ERROR.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, ERROR.
- IDLE, HALTED, ERROR + `start`:
  - pc := 0.
  - Next state FETCH.
  - `err` clears.
  - `start` is ignored in every other state.
- FETCH:
  - `imem_req` = 1 and `imem_addr` = pc.
  - On `imem_ack`: ir := `imem_rdata`; next state DECODE.
  - Without ack: stay in FETCH, with the request held.
- DECODE: if `dec_halt`, go to HALTED (pc unchanged). Otherwise go to EXEC.
- EXEC: if `dec_mem_write` or `dec_sel_wb`, go to MEM. Otherwise go to WB.
- MEM:
  - `dmem_req` = 1 and `dmem_we` = `dec_mem_write`.
  - On `dmem_ack`, go to WB.
- WB:
  - `rf_we` = `dec_reg_write` for exactly this cycle.
  - pc := `br_target` if (`br_taken` | `dec_jump`); otherwise pc + 1, wrapping modulo 2^PC_W (0xFFFF → 0x0000).
  - Next state FETCH.
- `ir` is stable from DECODE through WB. The decoder outputs are sampled only in those states.
- Reset, or `rst_n` low mid-instruction: state IDLE, pc 0, ir 0, and every output 0. An in-flight request is dropped with no completion.

## Timing
- Request outputs and strobes are Moore outputs, decoded from state (plus `dec_mem_write` for `dmem_we`, and `dec_reg_write` for `rf_we`).
- Ack arriving in the same cycle the request is first raised is legal.
- Non-memory instruction, zero-wait memory: 4 cycles, FETCH → WB.
- Memory instruction, zero-wait memory: 5 cycles. Each wait cycle on an ack adds one cycle.
- An ack seen outside FETCH or MEM is ignored.
- `imem_req` and `dmem_req` are never high in the same cycle.

## Configuration
- `CTRL_SEQ_TIMEOUT_EN` defined:
  - A TO_W-bit counter clears on entry to FETCH or MEM and increments each cycle the ack is low.
  - At 2^TO_W−1 with no ack, the next state is ERROR: `err` = 1 and the request drops.
  - An ack on the terminal-count cycle wins, and the timeout is not taken.
- Not defined: the block waits indefinitely, and `err` is tied 0.

## Structure
- `ctrl_seq_pkg` holds:
  - the state enum `ctrl_seq_state_t`;
  - the `IR_W` = 7 constant;
  - the IR field-slice constants.
- One sub-module, `ctrl_seq_wdog`: the timeout counter (clear/increment/terminal-count). It is instantiated only under `CTRL_SEQ_TIMEOUT_EN`.

## Test plan
- Reset, then `start`, with ALU instruction 0x05, `dec_reg_write`=1 and acks immediate → `imem_addr`=0; `rf_we` pulses once in cycle 4; pc = 1.
- Store, with `dec_mem_write`=1 and `dmem_ack` delayed 3 cycles → `dmem_req` high for 4 cycles with `dmem_we`=1; `rf_we` stays 0; total 8 cycles.
- Branch at pc 0x0010, `br_taken`=1, `br_target`=0x0002 → next `imem_addr`=0x0002. At pc 0xFFFF with no branch → next `imem_addr`=0x0000.
- `dec_halt`=1 → `halted`=1 after DECODE with pc unchanged; a `start` while halted → FETCH at pc 0.
- `rst_n` low during MEM with the request pending → all outputs 0 immediately; IDLE after release.
- With `CTRL_SEQ_TIMEOUT_EN` and TO_W=4, `imem_ack` held low → `err`=1 after 15 FETCH cycles and `imem_req` drops. An ack on cycle 15 → no error.
